unit_test_checker: RTL and testbench
====================================

UNIT_TEST_CHECKER -- requirements
Module: unit_test_checker

Interface
REQ-001 Parameter DATA_W, default 32, width of observed and expected values.
REQ-002 Parameter EXP_COUNT, default 4, number of expected values per test (1..16).
REQ-003 Parameter TIMEOUT, default 16, max idle cycles between accepted samples while running.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 exp_we  input  1  expected-table write strobe.
REQ-007 exp_addr  input  4  expected-table write index.
REQ-008 exp_data  input  DATA_W  expected-table write value.
REQ-009 start  input  1  one-cycle pulse; begins a check run.
REQ-010 in_valid  input  1  observed sample valid this cycle.
REQ-011 in_data  input  DATA_W  observed sample (DUT output such as out1).
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  one-cycle pulse on entry to DONE.
REQ-014 pass  output  1  sticky; high in DONE iff zero mismatches and no timeout.
REQ-015 mismatch_count  output  8  mismatches this run, saturating at 255.
REQ-016 first_bad_index  output  4  index of first mismatching sample; 4'hF if none.
REQ-017 timed_out  output  1  sticky; set on timeout.

Function
REQ-018 FSM in 8-bit fsmState, states IDLE=0, RUN=1, DONE=2.
REQ-019 IDLE: exp_we writes exp_data to table[exp_addr]; writes with exp_addr >= EXP_COUNT are ignored.
REQ-020 IDLE + start: clear sample index, mismatch_count, timed_out, pass, timer; first_bad_index=4'hF; go to RUN next cycle.
REQ-021 RUN: in_valid compares in_data to table[index] on the same cycle; on inequality mismatch_count increments, and first_bad_index takes index if it is still 4'hF.
REQ-022 RUN: each accepted sample increments index and clears timer; the sample at index EXP_COUNT-1 moves to DONE next cycle.
REQ-023 RUN: each cycle without in_valid increments timer; timer reaching TIMEOUT sets timed_out and moves to DONE.
REQ-024 Same cycle as the last sample and the timeout: the sample wins; no timeout.
REQ-025 DONE: done pulses for exactly the entry cycle; pass = (mismatch_count==0) && !timed_out; state returns to IDLE next cycle; results hold until the next start.
REQ-026 start during RUN or DONE is ignored; exp_we during RUN or DONE is ignored.
REQ-027 in_valid in IDLE or DONE is ignored; counters do not change.
REQ-028 Comparison is full DATA_W unsigned equality; no sign handling.
REQ-029 Latency from start to first accepted sample: 1 cycle; from last sample to done: 1 cycle.

Reset
REQ-030 reset low forces IDLE immediately: busy=0, done=0, pass=0, mismatch_count=0, first_bad_index=4'hF, timed_out=0, index=0, timer=0.
REQ-031 Table contents are zeroed on reset.
REQ-032 reset asserted during RUN aborts the run; no done pulse is issued.

Structure
REQ-033 Package unit_test_checker_pkg holds the state encodings IDLE/RUN/DONE, the NO_BAD_INDEX=4'hF constant and the default parameter values.
REQ-034 The expected table is sub-module unit_test_checker_table (write port, combinational read, async-low reset); the FSM, timer and counters stay in the top level.

Verification
REQ-035 Load table {8,8,8,8}; start; feed 8,8,8,8 back-to-back -> done 1 cycle after last sample, pass=1, mismatch_count=0, first_bad_index=F.
REQ-036 Load table {8,7,8,0x35}; feed 8,8,8,8 -> pass=0, mismatch_count=2, first_bad_index=1.
REQ-037 Start, feed 2 samples, then idle 16 cycles -> timed_out=1, pass=0, done pulses once, busy falls with done.
REQ-038 Last sample on the same cycle as timer reaching TIMEOUT -> timed_out=0, pass reflects the compare only.
REQ-039 Drop reset mid-RUN after 2 samples -> all outputs at reset values, no done; a new start and 4 correct samples -> pass=1.
REQ-040 exp_we while busy, and a second start while busy -> table and run unchanged; the result matches a clean run.

Source files
------------

// File: rtl/unit_test_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unit_test_checker_pkg
// Description : Shared state encodings, constants and default parameter
//               values for the unit test checker.
// Revision    : 1.0 - initial release
// ============================================================================
package unit_test_checker_pkg;

    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_EXP_COUNT = 4;
    localparam int DEFAULT_TIMEOUT   = 16;

    // Reported as first_bad_index when every sample matched.
    localparam logic [3:0] NO_BAD_INDEX = 4'hF;

    typedef enum logic [7:0] {
        IDLE = 8'd0,
        RUN  = 8'd1,
        DONE = 8'd2
    } state_t;

    // Mismatch counter increment that sticks at the top of its range.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unit_test_checker_table.sv
`default_nettype none
// ============================================================================
// Module      : unit_test_checker_table
// Description : Expected-value table. One write port, combinational read,
//               contents cleared by the asynchronous active-low reset.
//               Writes to entries at or beyond DEPTH are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module unit_test_checker_table
    import unit_test_checker_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_EXP_COUNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage: address decode by comparison so out-of-range writes hit nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr == 4'(i)) begin
                    r_mem[i] <= wdata;
                end
            end
        end
    end

    // Combinational read; an index past the table reads as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == 4'(i)) begin
                rdata = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/unit_test_checker.sv
`default_nettype none
// ============================================================================
// Module      : unit_test_checker
// Description : Compares a stream of observed samples against a preloaded
//               table of expected values, counting mismatches, recording the
//               first bad index and flagging an idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module unit_test_checker
    import unit_test_checker_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int EXP_COUNT = DEFAULT_EXP_COUNT,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_we,
    input  logic [3:0]        exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        mismatch_count,
    output logic [3:0]        first_bad_index,
    output logic              timed_out
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_index;
    logic [TMR_W-1:0]  r_timer;
    logic [7:0]        r_mis_cnt;
    logic [3:0]        r_first_bad;
    logic              r_pass;
    logic              r_timed_out;

    logic [DATA_W-1:0] w_exp_rd;
    logic              w_start;
    logic              w_accept;
    logic              w_idle_tick;
    logic              w_last;
    logic              w_miss;
    logic [TMR_W-1:0]  w_timer_inc;
    logic              w_timeout;

    // Table writes are only honoured while idle so a running check is stable.
    unit_test_checker_table #(
        .DATA_W (DATA_W),
        .DEPTH  (EXP_COUNT)
    ) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (exp_we && (r_state == IDLE)),
        .waddr (exp_addr),
        .wdata (exp_data),
        .raddr (r_index),
        .rdata (w_exp_rd)
    );

    assign w_start     = (r_state == IDLE) && start;
    assign w_accept    = (r_state == RUN) && in_valid;
    assign w_idle_tick = (r_state == RUN) && !in_valid;
    assign w_last      = w_accept && (r_index == 4'(EXP_COUNT - 1));
    assign w_miss      = w_accept && (in_data != w_exp_rd);
    assign w_timer_inc = r_timer + TMR_W'(1);
    // A cycle with a sample never advances the timer, so the last sample
    // always beats a timeout landing on the same cycle.
    assign w_timeout   = w_idle_tick && (w_timer_inc == TMR_W'(TIMEOUT));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; DONE lasts exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last || w_timeout) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Run counters, timer and sticky results; results are frozen outside RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_index     <= '0;
            r_timer     <= '0;
            r_mis_cnt   <= '0;
            r_first_bad <= NO_BAD_INDEX;
            r_pass      <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (w_start) begin
            r_index     <= '0;
            r_timer     <= '0;
            r_mis_cnt   <= '0;
            r_first_bad <= NO_BAD_INDEX;
            r_pass      <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (w_accept) begin
            r_index <= r_index + 4'd1;
            r_timer <= '0;
            if (w_miss) begin
                r_mis_cnt <= sat_inc8(r_mis_cnt);
                if (r_first_bad == NO_BAD_INDEX) begin
                    r_first_bad <= r_index;
                end
            end
            // Pass is resolved on the way into DONE so it is valid with done.
            if (w_last) begin
                r_pass <= (r_mis_cnt == 8'd0) && !w_miss;
            end
        end else if (w_idle_tick) begin
            r_timer <= w_timer_inc;
            if (w_timeout) begin
                r_timed_out <= 1'b1;
                r_pass      <= 1'b0;
            end
        end
    end

    assign busy            = (r_state == RUN);
    assign done            = (r_state == DONE);
    assign pass            = r_pass;
    assign mismatch_count  = r_mis_cnt;
    assign first_bad_index = r_first_bad;
    assign timed_out       = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_unit_test_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_unit_test_checker
// Description : Scoreboard bench for unit_test_checker. The driver plays
//               directed and random runs and queues the result predicted by
//               a run-level model; a monitor pops on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unit_test_checker;

    localparam int DW = 32;
    localparam int EC = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          exp_we;
    logic [3:0]    exp_addr;
    logic [DW-1:0] exp_data;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          busy;
    logic          done;
    logic          pass;
    logic [7:0]    mismatch_count;
    logic [3:0]    first_bad_index;
    logic          timed_out;

    unit_test_checker #(
        .DATA_W    (DW),
        .EXP_COUNT (EC),
        .TIMEOUT   (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .exp_we          (exp_we),
        .exp_addr        (exp_addr),
        .exp_data        (exp_data),
        .start           (start),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .mismatch_count  (mismatch_count),
        .first_bad_index (first_bad_index),
        .timed_out       (timed_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit pass;
        int mis;
        int fb;
        bit to;
        int done_cyc;
    } exp_t;

    exp_t          sb_q[$];
    int            total = 0;
    int            bad = 0;

    logic [DW-1:0] tab_m   [16];
    logic [DW-1:0] new_tab [16];
    int            gap     [16];
    logic [DW-1:0] val     [16];
    int            nsamp;

    task automatic chk(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // One table write from IDLE; the model keeps only in-range entries.
    task automatic tb_write(input int addr, input logic [DW-1:0] data);
        exp_we   = 1'b1;
        exp_addr = 4'(addr);
        exp_data = data;
        if (addr < EC) tab_m[addr] = data;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic load_table();
        for (int k = 0; k < EC; k++) tb_write(k, new_tab[k]);
        tb_write($urandom_range(15, EC), $urandom);
    endtask

    // Run-level prediction: walk the sample schedule, stop at the first
    // idle stretch of TO cycles. done_cyc is the run length in cycles.
    function automatic exp_t model();
        exp_t e;
        int   r   = 0;
        int   acc = 0;
        e.mis = 0;
        e.fb  = 15;
        e.to  = 1'b0;
        for (int k = 0; k < nsamp; k++) begin
            if (gap[k] >= TO) break;
            r += gap[k];
            if (val[k] != tab_m[k]) begin
                if (e.mis == 0) e.fb = k;
                e.mis++;
            end
            acc++;
            r++;
        end
        if (acc < EC) begin
            e.to = 1'b1;
            r += TO;
        end
        if (e.mis > 255) e.mis = 255;
        e.pass     = (e.mis == 0) && !e.to;
        e.done_cyc = r;
        return e;
    endfunction

    // Plays one full run; inj adds table writes and starts that must be ignored.
    task automatic do_run(input bit do_load, input bit inj);
        exp_t e;
        int   end_rel;
        int   k;
        int   left;
        if (do_load) load_table();
        e       = model();
        end_rel = e.done_cyc;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        e.done_cyc = cyc + end_rel;
        sb_q.push_back(e);
        chk("busy_in_run", busy, 1);
        k    = 0;
        left = gap[0];
        for (int rel = 0; rel < end_rel; rel++) begin
            if (k < nsamp && left == 0) begin
                in_valid = 1'b1;
                in_data  = val[k];
                k++;
                left = (k < nsamp) ? gap[k] : 0;
            end else begin
                in_valid = 1'b0;
                in_data  = $urandom;
                if (left > 0) left--;
            end
            if (inj && $urandom_range(3, 0) == 0) begin
                exp_we   = 1'b1;
                exp_addr = 4'($urandom_range(EC - 1, 0));
                exp_data = $urandom;
                start    = 1'b1;
            end else begin
                exp_we = 1'b0;
                start  = 1'b0;
            end
            tick();
        end
        // DONE cycle: stray sample, write and start must all be ignored.
        in_valid = 1'b1;
        in_data  = $urandom;
        if (inj) begin
            exp_we   = 1'b1;
            exp_addr = '0;
            exp_data = $urandom;
            start    = 1'b1;
        end
        tick();
        drive_idle();
    endtask

    task automatic set_plain(input logic [DW-1:0] t0, t1, t2, t3,
                             input logic [DW-1:0] v0, v1, v2, v3);
        new_tab[0] = t0; new_tab[1] = t1; new_tab[2] = t2; new_tab[3] = t3;
        val[0] = v0; val[1] = v1; val[2] = v2; val[3] = v3;
        for (int k = 0; k < 16; k++) gap[k] = 0;
        nsamp = EC;
    endtask

    task automatic set_random(input bit ld);
        for (int k = 0; k < EC; k++) begin
            int r;
            logic [DW-1:0] base;
            new_tab[k] = $urandom;
            base = ld ? new_tab[k] : tab_m[k];
            r = $urandom_range(9, 0);
            gap[k] = (r < 7) ? 0 : (r < 9) ? $urandom_range(3, 1) : $urandom_range(17, 14);
            val[k] = ($urandom_range(3, 0) == 0) ? (base ^ (32'h1 << $urandom_range(31, 0))) : base;
        end
        nsamp = EC;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_mis"}, mismatch_count, 0);
        chk({tag, "_fbi"}, first_bad_index, 15);
        chk({tag, "_to"}, timed_out, 0);
    endtask

    // Monitor: every done pulse must match the oldest queued prediction,
    // and the results must still hold one cycle later.
    initial begin
        exp_t e;
        exp_t last;
        bit   hold = 1'b0;
        forever begin
            @(negedge clk);
            if (hold) begin
                hold = 1'b0;
                chk("hold_pass", pass, last.pass);
                chk("hold_mis", mismatch_count, last.mis);
                chk("hold_fbi", first_bad_index, last.fb);
                chk("hold_to", timed_out, last.to);
            end
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done at cycle %0d: no run outstanding", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("busy_at_done", busy, 0);
                    chk("pass", pass, e.pass);
                    chk("mismatch_count", mismatch_count, e.mis);
                    chk("first_bad_index", first_bad_index, e.fb);
                    chk("timed_out", timed_out, e.to);
                    last = e;
                    hold = 1'b1;
                end
            end else if (sb_q.size() > 0 && cyc > sb_q[0].done_cyc) begin
                total++;
                bad++;
                $display("FAIL done_missing: none by cycle %0d, required at %0d", cyc, sb_q[0].done_cyc);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        for (int k = 0; k < 16; k++) tab_m[k] = '0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        tick();
        reset = 1'b1;
        tick();

        // All samples match, back to back.
        set_plain(8, 8, 8, 8, 8, 8, 8, 8);
        do_run(1'b1, 1'b0);

        // Two mismatches, first at index 1.
        set_plain(8, 7, 8, 32'h35, 8, 8, 8, 8);
        do_run(1'b1, 1'b0);

        // Two samples then starvation.
        set_plain(8, 8, 8, 8, 8, 8, 8, 8);
        nsamp = 2;
        do_run(1'b1, 1'b0);

        // Last sample arrives after TO-1 idle cycles: sample wins.
        set_plain(8, 8, 8, 8, 8, 8, 8, 8);
        gap[3] = TO - 1;
        do_run(1'b1, 1'b0);
        set_plain(8, 8, 8, 8, 8, 8, 8, 9);
        gap[3] = TO - 1;
        do_run(1'b1, 1'b0);

        // One more idle cycle and it is a timeout.
        set_plain(8, 8, 8, 8, 8, 8, 8, 8);
        gap[3] = TO;
        do_run(1'b1, 1'b0);

        // Top-bit difference must count as a mismatch.
        set_plain(0, 32'h8000_0000, 5, 5, 0, 0, 5, 5);
        do_run(1'b1, 1'b0);

        // Reset in the middle of a run: abort, no done, table cleared.
        new_tab[0] = 5; new_tab[1] = 6; new_tab[2] = 7; new_tab[3] = 8;
        load_table();
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 5;
        tick();
        in_data = 6;
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk_reset_vals("abort");
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 16; k++) tab_m[k] = '0;
        tick();
        set_plain(0, 0, 0, 0, 0, 0, 0, 0);
        do_run(1'b0, 1'b0);
        set_plain(5, 6, 7, 8, 5, 6, 7, 8);
        do_run(1'b1, 1'b0);

        // Writes and restarts while busy must not disturb a run.
        set_plain(1, 2, 3, 4, 1, 2, 3, 4);
        do_run(1'b1, 1'b1);
        set_plain(1, 2, 3, 4, 1, 9, 3, 4);
        do_run(1'b1, 1'b1);

        // Random runs.
        for (int n = 0; n < 40; n++) begin
            bit ld;
            ld = ($urandom_range(3, 0) != 0);
            set_random(ld);
            do_run(ld, ($urandom_range(1, 0) == 1));
        end

        tick();
        tick();
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
